// File: rtl/olivia_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state type and the doubleword addressing constants.
package olivia_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } mem_state_e;

    localparam int unsigned DW_BYTES   = 8;
    localparam int unsigned DW_SHIFT   = 3;
    localparam logic [2:0]  ALIGN_MASK = 3'b111;

    // Misaligned or beyond the stored range; the full 61-bit index is compared, never wrapped.
    function automatic logic addr_err(input logic [63:0] addr, input int unsigned depth);
        return ((addr[DW_SHIFT-1:0] & ALIGN_MASK) != 3'b000) ||
               ({3'b000, addr[63:DW_SHIFT]} >= 64'(depth));
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core and the data memory.
// The core drives through the master modport; the responder uses slave.
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_responder_dm_array.sv
// Doubleword storage: synchronous write, combinational read by index.
// Contents are deliberately not reset.
module dm_array #(
    parameter int unsigned DEPTH_DW = 128,
    parameter int unsigned IDX_W    = 7
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [63:0]      wdata_i,
    output logic [63:0]      rdata_o
);

    logic [63:0] mem_q [DEPTH_DW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, fixed wait states,
// response held until consumed. Array commit happens on the edge that raises rsp_valid.
module data_mem_responder
    import olivia_mem_pkg::*;
#(
    parameter int unsigned DEPTH_DW = 128,
    parameter int unsigned LATENCY  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned DwBits = DW_BYTES * 8;
    localparam int unsigned IdxW   = (DEPTH_DW > 1) ? $clog2(DEPTH_DW) : 1;
    localparam int unsigned CntW   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CntW-1:0] CntInit = (LATENCY > 0) ? CntW'(LATENCY - 1) : '0;

    mem_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [63:0]       addr_q, addr_d;
    logic [DwBits-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DwBits-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              req_ready;
    logic              err;
    logic              arr_we;
    logic [DwBits-1:0] arr_rdata;

    dm_array #(
        .DEPTH_DW (DEPTH_DW),
        .IDX_W    (IdxW)
    ) u_dm_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .idx_i   (addr_q[IdxW+DW_SHIFT-1:DW_SHIFT]),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    // Gated by rst so nothing is accepted (or committed) while reset is asserted.
    assign req_ready = rst && (state_q == StIdle);
    assign err       = addr_err(addr_q, DEPTH_DW);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        arr_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid && req_ready) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (LATENCY == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if (!rsp_valid_q) begin
                    // First RESP cycle: check, commit/read, and raise the response together.
                    arr_we      = write_q && !err;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err;
                    rsp_rdata_d = (write_q || err) ? '0 : arr_rdata;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
